spi_read: RTL and testbench

SPI_READ -- requirements
Module: spi_read

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_gen.sv | 34 +++
 rtl/spi_read.sv | 155 +++++++++++++++
 tb/tb_spi_read.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the read and write blocks: FSM state
// encoding and header field lengths.
package spi_pkg;

    localparam int unsigned ADDR_BITS  = 8;
    localparam int unsigned COUNT_BITS = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND_ADDR  = 3'd1,
        SEND_COUNT = 3'd2,
        RECV       = 3'd3,
        DONE       = 3'd4
    } spi_state_e;

    // States in which the SPI clock runs.
    function automatic logic is_active(spi_state_e s);
        return (s == SEND_ADDR) || (s == SEND_COUNT) || (s == RECV);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI bit-clock generator: each bit is one low clk cycle then one high
// clk cycle; strobes mark the edge that ends a high phase.
module spi_clk_gen (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    output logic spi_clk,
    output logic shift_en_c,
    output logic sample_en_c
);

    logic phase_q;
    logic phase_d;

    always_comb begin
        phase_d = enable ? ~phase_q : 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign spi_clk = phase_q;

    // The edge closing a high phase both samples the target and opens the
    // next low phase, where the controller presents its next bit.
    assign sample_en_c = enable & phase_q;
    assign shift_en_c  = enable & phase_q;

endmodule

// File: rtl/spi_read.sv
// SPI register-read controller: sends start address and word count, then
// shifts in count words of REG_WIDTH bits from the target, MSB first.
module spi_read
    import spi_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 serial_in,
    input  logic                 new_command,
    input  logic [ADDR_BITS-1:0] start_read_register_addr,
    input  logic [COUNT_BITS-1:0] num_regs_to_read,
    output logic [REG_WIDTH-1:0] data_read_from_reg,
    output logic                 data_valid,
    output logic                 serial_out,
    output logic                 spi_clk,
    output logic                 transaction_complete
);

    localparam int unsigned MAX_BITS  = (REG_WIDTH > ADDR_BITS) ? REG_WIDTH : ADDR_BITS;
    localparam int unsigned BIT_CNT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    spi_state_e             state_q, state_d;
    logic                   cmd_prev_q;
    logic [ADDR_BITS-1:0]   tx_q, tx_d;
    logic [REG_WIDTH-1:0]   rx_q, rx_d;
    logic [REG_WIDTH-1:0]   rx_shift;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic [COUNT_BITS-1:0]  words_q, words_d;
    logic [REG_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   cmd_rise;
    logic                   shift_en;
    logic                   sample_en;

    spi_clk_gen u_clk_gen (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (is_active(state_q)),
        .spi_clk     (spi_clk),
        .shift_en_c  (shift_en),
        .sample_en_c (sample_en)
    );

    assign cmd_rise = new_command & ~cmd_prev_q;
    assign rx_shift = REG_WIDTH'({rx_q, serial_in});

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        words_d = words_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_rise) begin
                    words_d = num_regs_to_read;
                    bit_d   = BIT_CNT_W'(ADDR_BITS - 1);
                    rx_d    = '0;
                    if (num_regs_to_read == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND_ADDR;
                        tx_d    = start_read_register_addr;
                    end
                end
            end
            SEND_ADDR: begin
                if (shift_en) begin
                    if (bit_q == '0) begin
                        state_d = SEND_COUNT;
                        tx_d    = ADDR_BITS'(words_q);
                        bit_d   = BIT_CNT_W'(COUNT_BITS - 1);
                    end else begin
                        tx_d  = {tx_q[ADDR_BITS-2:0], 1'b0};
                        bit_d = bit_q - BIT_CNT_W'(1);
                    end
                end
            end
            SEND_COUNT: begin
                if (shift_en) begin
                    if (bit_q == '0) begin
                        state_d = RECV;
                        tx_d    = '0;
                        bit_d   = BIT_CNT_W'(REG_WIDTH - 1);
                    end else begin
                        tx_d  = {tx_q[ADDR_BITS-2:0], 1'b0};
                        bit_d = bit_q - BIT_CNT_W'(1);
                    end
                end
            end
            RECV: begin
                if (sample_en) begin
                    rx_d = rx_shift;
                    if (bit_q == '0) begin
                        data_d  = rx_shift;
                        valid_d = 1'b1;
                        words_d = words_q - COUNT_BITS'(1);
                        bit_d   = BIT_CNT_W'(REG_WIDTH - 1);
                        if (words_q == COUNT_BITS'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        bit_d = bit_q - BIT_CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cmd_prev_q <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            words_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_prev_q <= new_command;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            words_q    <= words_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    // tx_q is zero outside the header, so its MSB is the line value.
    assign serial_out           = tx_q[ADDR_BITS-1];
    assign data_read_from_reg   = data_q;
    assign data_valid           = valid_q;
    assign transaction_complete = done_q;

endmodule

// File: tb/tb_spi_read.sv
// Directed bench for spi_read: table of read transactions checked cycle by
// cycle against a timing model, plus reset abort / reset-release sequences.
module tb_spi_read;

    logic       clk;
    logic       rstn;
    logic       serial_in;
    logic       new_command;
    logic [7:0] start_read_register_addr;
    logic [7:0] num_regs_to_read;
    logic [7:0] data_read_from_reg;
    logic       data_valid;
    logic       serial_out;
    logic       spi_clk;
    logic       transaction_complete;

    int checks = 0;
    int errors = 0;
    int model_data = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] cnt;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         hold;
        int         glitch;
        bit         change;
        int         exp_tc;
    } vec_t;

    vec_t vecs[6];

    spi_read #(.REG_WIDTH(8)) dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .serial_in                (serial_in),
        .new_command              (new_command),
        .start_read_register_addr (start_read_register_addr),
        .num_regs_to_read         (num_regs_to_read),
        .data_read_from_reg       (data_read_from_reg),
        .data_valid               (data_valid),
        .serial_out               (serial_out),
        .spi_clk                  (spi_clk),
        .transaction_complete     (transaction_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic logic [7:0] word_of(input vec_t v, input int w);
        if (w == 0) return v.w0;
        if (w == 1) return v.w1;
        if (w == 2) return v.w2;
        return 8'(w * 7 + 1);
    endfunction

    // One read; cycle n is the clk period after the n-th edge following
    // the edge that samples the new_command rise.
    task automatic run_txn(input vec_t v, input bit rel);
        int nw;
        int last_n;
        int len;
        int so_err, ck_err, dv_err, dt_err, tc_err, tc_cnt, tc_first;
        int exp_so, exp_ck, exp_dv, exp_tc, idx;
        logic [7:0] wv;
        nw       = int'(v.cnt);
        last_n   = (nw == 0) ? 1 : 33 + 16 * nw;
        len      = (last_n + 4 > v.hold + 4) ? last_n + 4 : v.hold + 4;
        so_err   = 0; ck_err = 0; dv_err = 0; dt_err = 0; tc_err = 0;
        tc_cnt   = 0; tc_first = -1;

        @(negedge clk);
        start_read_register_addr = v.addr;
        num_regs_to_read         = v.cnt;
        new_command              = 1'b1;
        if (rel) rstn = 1'b1;
        @(posedge clk);

        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            exp_ck = (nw > 0 && n < 32 + 16 * nw) ? (n % 2) : 0;
            if (nw > 0 && n < 16)      exp_so = int'((v.addr >> (7 - n / 2)) & 8'h01);
            else if (nw > 0 && n < 32) exp_so = int'((v.cnt >> (7 - (n - 16) / 2)) & 8'h01);
            else                       exp_so = 0;
            exp_dv = (nw > 0 && n >= 48 && n <= 32 + 16 * nw && (n - 32) % 16 == 0) ? 1 : 0;
            if (exp_dv == 1) model_data = int'(word_of(v, (n - 48) / 16));
            exp_tc = (n == last_n) ? 1 : 0;

            if (int'(serial_out) != exp_so) so_err++;
            if (int'(spi_clk) != exp_ck) ck_err++;
            if (int'(data_valid) != exp_dv) dv_err++;
            if (int'(data_read_from_reg) != model_data) dt_err++;
            if (int'(transaction_complete) != exp_tc) tc_err++;
            if (transaction_complete) begin
                tc_cnt++;
                if (tc_first < 0) tc_first = n;
            end

            if (nw > 0 && n >= 32 && n < 32 + 16 * nw) begin
                idx       = (n - 32) / 2;
                wv        = word_of(v, idx / 8);
                serial_in = wv[7 - (idx % 8)];
            end else begin
                serial_in = 1'b1;
            end
            if (v.change && n == 0) begin
                start_read_register_addr = ~v.addr;
                num_regs_to_read         = v.cnt ^ 8'h0F;
            end
            if (v.glitch >= 0 && n == v.glitch)     new_command = 1'b0;
            if (v.glitch >= 0 && n == v.glitch + 2) new_command = 1'b1;
            if (n + 1 == v.hold)                    new_command = 1'b0;
        end
        new_command = 1'b0;

        check($sformatf("serial_out_mismatches addr=%0h cnt=%0d", v.addr, nw), so_err, 0);
        check($sformatf("spi_clk_mismatches addr=%0h cnt=%0d", v.addr, nw), ck_err, 0);
        check($sformatf("data_valid_mismatches addr=%0h cnt=%0d", v.addr, nw), dv_err, 0);
        check($sformatf("data_mismatches addr=%0h cnt=%0d", v.addr, nw), dt_err, 0);
        check($sformatf("complete_mismatches addr=%0h cnt=%0d", v.addr, nw), tc_err, 0);
        check($sformatf("complete_pulses addr=%0h cnt=%0d", v.addr, nw), tc_cnt, 1);
        check($sformatf("complete_cycle addr=%0h cnt=%0d", v.addr, nw), tc_first, v.exp_tc);
    endtask

    initial begin
        int act;
        vec_t rv;

        vecs[0] = '{8'h12, 8'd1,   8'hA5, 8'h00, 8'h00, 1,   -1, 1'b0, 49};
        vecs[1] = '{8'h00, 8'd3,   8'h01, 8'h80, 8'hFF, 1,   -1, 1'b0, 81};
        vecs[2] = '{8'hFF, 8'd0,   8'h00, 8'h00, 8'h00, 1,   -1, 1'b0, 1};
        vecs[3] = '{8'h5C, 8'd2,   8'h5A, 8'h3C, 8'h00, 100, 40, 1'b0, 65};
        vecs[4] = '{8'hA7, 8'd2,   8'hC3, 8'h0E, 8'h00, 1,   -1, 1'b1, 65};
        vecs[5] = '{8'h80, 8'd255, 8'h96, 8'h69, 8'h11, 1,   -1, 1'b0, 4113};
        rv      = '{8'h33, 8'd2,   8'hE7, 8'h18, 8'h00, 1,   -1, 1'b0, 65};

        rstn = 1'b0; serial_in = 1'b0; new_command = 1'b0;
        start_read_register_addr = 8'h00; num_regs_to_read = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({data_read_from_reg, data_valid, serial_out, spi_clk, transaction_complete}), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], 1'b0);
        end

        // Abort a count-2 read in cycle 40 with reset.
        @(negedge clk);
        start_read_register_addr = rv.addr;
        num_regs_to_read         = rv.cnt;
        new_command              = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            serial_in = 1'b1;
            if (n == 0) new_command = 1'b0;
        end
        @(negedge clk);
        check("abort_in_recv_data_nonzero", int'(data_read_from_reg != 8'h00), 1);
        rstn = 1'b0;
        #1;
        check("abort_outputs", int'({data_read_from_reg, data_valid, serial_out, spi_clk, transaction_complete}), 0);
        model_data = 0;
        act = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            act += int'(data_valid) + int'(transaction_complete) + int'(spi_clk);
        end
        rstn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            act += int'(data_valid) + int'(transaction_complete) + int'(spi_clk) + int'(serial_out);
        end
        check("no_activity_after_abort", act, 0);

        run_txn(rv, 1'b0);

        // new_command held high across reset release starts a read.
        @(negedge clk);
        rstn        = 1'b0;
        new_command = 1'b1;
        model_data  = 0;
        run_txn(vecs[0], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
